exe_share_arb: RTL and testbench
================================

# exe_share_arb

Two-requester arbiter and sequencer for the shared I-type execute unit. It accepts operand/instruction bundles from two requesters over valid/ready handshakes and presents one bundle at a time to the combinational execute unit from registered hold registers. It captures the unit's write-back result and returns it with the requester's tag over a valid/ready response channel. It sits between the issue logic (requester 0 = main pipeline, requester 1 = auxiliary/debug issue) and the execute unit.

## Interface
- DATA_WIDTH, 32, operand and result width; must match `DATA_WIDTH`/`RDATA_WIDTH`.
- TAG_WIDTH, 4, width of the opaque requester tag.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req0_valid_i / req1_valid_i  in  1  request present.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle.
- req0_op1_i / req1_op1_i  in  DATA_WIDTH  operand 1.
- req0_op2_i / req1_op2_i  in  DATA_WIDTH  operand 2 (immediate).
- req0_inst_i / req1_inst_i  in  32  instruction word.
- req0_tag_i / req1_tag_i  in  TAG_WIDTH  tag echoed on the response.
- exe_op1_o, exe_op2_o  out  DATA_WIDTH  operands to the execute unit.
- exe_inst_o  out  32  instruction to the execute unit.
- exe_wdata_i  in  DATA_WIDTH  execute result.
- exe_we_i  in  1  execute write enable.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_id_o  out  1  requester index (0/1) of the response.
- rsp_tag_o  out  TAG_WIDTH  echoed tag.
- rsp_wdata_o  out  DATA_WIDTH  captured result.
- rsp_we_o  out  1  captured write enable.
- busy_o  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Accept window: the state is IDLE, or the state is RESP with rsp_ready_i=1.
- In the accept window, if any reqN_valid_i=1, grant one requester:
  - reqN_ready_o=1 for the granted requester only (combinational).
  - Latch its op1/op2/inst/tag and index into the hold registers.
  - Next state: EXEC.
- With no valid request in the accept window, the next state is IDLE.
- Each reqN_ready_o is combinational from both valids and the state. A requester must not make its valid depend on its ready.
- EXEC lasts one cycle:
  - exe_*_o are driven from the hold registers.
  - exe_wdata_i/exe_we_i are captured into rsp_wdata_o/rsp_we_o at the end of the cycle.
  - Next state: RESP.
- RESP:
  - rsp_valid_o=1; all rsp_* outputs are stable until the handshake completes.
  - On rsp_valid_o & rsp_ready_i the response retires.
- Outside EXEC, exe_op1_o, exe_op2_o and exe_inst_o are 0. Opcode 0 keeps the unit's write enable deasserted.
- Arbitration: a pointer `prio` gives the winner on a tie. After a grant to requester N, prio ← ~N. A single valid requester always wins.
- Non-I-type instructions are passed through unchanged. The unit's zero result with we=0 is returned as a normal response.

## Timing
- Reset: state=IDLE, prio=0. All outputs are 0: rsp_valid_o, rsp_we_o, rsp_wdata_o, rsp_tag_o, rsp_id_o, reqN_ready_o, exe_*_o, busy_o.
- Latency: a request accepted at edge N is presented to the unit during cycle N+1. rsp_valid_o is high from the cycle after edge N+1.
- Throughput: one request per 2 cycles with rsp_ready_i held high, because RESP accepts back-to-back.
- Simultaneous events:
  - Both requesters valid: exactly one ready, chosen by prio.
  - Retire and accept in the same RESP cycle: the old response retires and the new bundle is latched. rsp_valid_o drops for exactly the EXEC cycle.
- Backpressure: if rsp_ready_i=0 in RESP, both reqN_ready_o stay 0 indefinitely and the response holds.
- Reset mid-operation: asynchronous return to IDLE. A request in flight and a pending response are discarded with no response. prio returns to 0.

## Configuration
- EXE_ARB_RR_EN defined: round-robin arbitration using `prio` as described.
- EXE_ARB_RR_EN undefined: fixed priority; requester 0 always wins a tie. The prio register is not implemented.

## Test plan
- Single ADDI: req0 op1=5, op2=7, inst=0x00000093, tag=3.
  - req0_ready_o pulses 1 cycle, busy_o rises.
  - After 2 cycles: rsp_valid_o=1, rsp_wdata_o=12, rsp_we_o=1, rsp_id_o=0, rsp_tag_o=3.
- Tie arbitration: both requesters valid continuously. req0 carries ORI op1=0xF0, op2=0x0F, inst=0x0000E093; req1 carries ANDI op1=0xFF, op2=0x0F, inst=0x0000F093; rsp_ready_i=1.
  - With EXE_ARB_RR_EN: rsp_id_o alternates 0,1,0,1 and rsp_wdata_o alternates 0xFF, 0x0F.
  - Without EXE_ARB_RR_EN: rsp_id_o is 0 every time.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with req1 valid.
  - The response holds stable and req1_ready_o=0 throughout.
  - Raising rsp_ready_i retires the response and accepts req1 in the same cycle.
- Non-I-type: inst=0x00000033, op1=9, op2=9 → response with rsp_wdata_o=0, rsp_we_o=0.
- Reset in EXEC: assert rst_i asynchronously.
  - All outputs go to 0 immediately and the state is IDLE.
  - No response appears after release.
  - The next request completes normally with 2-cycle latency.

Source files
------------

// File: rtl/exe_share_arb.sv
// Two-requester arbiter/sequencer for the shared I-type execute unit.
// Define EXE_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module exe_share_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_op1_i,
  input  logic [DATA_WIDTH-1:0] req0_op2_i,
  input  logic [31:0]           req0_inst_i,
  input  logic [TAG_WIDTH-1:0]  req0_tag_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_op1_i,
  input  logic [DATA_WIDTH-1:0] req1_op2_i,
  input  logic [31:0]           req1_inst_i,
  input  logic [TAG_WIDTH-1:0]  req1_tag_i,
  output logic [DATA_WIDTH-1:0] exe_op1_o,
  output logic [DATA_WIDTH-1:0] exe_op2_o,
  output logic [31:0]           exe_inst_o,
  input  logic [DATA_WIDTH-1:0] exe_wdata_i,
  input  logic                  exe_we_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic [DATA_WIDTH-1:0] rsp_wdata_o,
  output logic                  rsp_we_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] exe_op1_q, exe_op1_d;
  logic [DATA_WIDTH-1:0] exe_op2_q, exe_op2_d;
  logic [31:0]           exe_inst_q, exe_inst_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [DATA_WIDTH-1:0] rsp_wdata_q, rsp_wdata_d;
  logic                  rsp_we_q, rsp_we_d;
  logic                  busy_q, busy_d;
  logic                  accept_win_c;
  logic                  grant0_c;
  logic                  grant1_c;
  logic                  tie_to1_c;

`ifdef EXE_ARB_RR_EN
  logic prio_q, prio_d;
  assign tie_to1_c = prio_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  always_comb begin
    prio_d = prio_q;
    if (grant0_c || grant1_c) prio_d = grant0_c;
  end
`else
  assign tie_to1_c = 1'b0;
`endif

  // Next-state, grant and hold-register loading; exe_* hold data only for the EXEC cycle.
  always_comb begin
    state_d      = state_q;
    exe_op1_d    = '0;
    exe_op2_d    = '0;
    exe_inst_d   = '0;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_wdata_d  = rsp_wdata_q;
    rsp_we_d     = rsp_we_q;
    accept_win_c = 1'b0;
    grant0_c     = 1'b0;
    grant1_c     = 1'b0;

    case (state_q)
      S_IDLE: accept_win_c = 1'b1;
      S_EXEC: begin
        state_d     = S_RESP;
        rsp_wdata_d = exe_wdata_i;
        rsp_we_d    = exe_we_i;
      end
      S_RESP:  accept_win_c = rsp_ready_i;
      default: state_d = S_IDLE;
    endcase

    if (accept_win_c && !rst_i) begin
      grant1_c = req1_valid_i && (!req0_valid_i || tie_to1_c);
      grant0_c = req0_valid_i && !grant1_c;
      state_d  = (grant0_c || grant1_c) ? S_EXEC : S_IDLE;
    end

    if (grant1_c) begin
      exe_op1_d  = req1_op1_i;
      exe_op2_d  = req1_op2_i;
      exe_inst_d = req1_inst_i;
      rsp_tag_d  = req1_tag_i;
      rsp_id_d   = 1'b1;
    end else if (grant0_c) begin
      exe_op1_d  = req0_op1_i;
      exe_op2_d  = req0_op2_i;
      exe_inst_d = req0_inst_i;
      rsp_tag_d  = req0_tag_i;
      rsp_id_d   = 1'b0;
    end

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      exe_op1_q   <= '0;
      exe_op2_q   <= '0;
      exe_inst_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_wdata_q <= '0;
      rsp_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exe_op1_q   <= exe_op1_d;
      exe_op2_q   <= exe_op2_d;
      exe_inst_q  <= exe_inst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_wdata_q <= rsp_wdata_d;
      rsp_we_q    <= rsp_we_d;
      busy_q      <= busy_d;
    end
  end

  assign req0_ready_o = grant0_c;
  assign req1_ready_o = grant1_c;
  assign exe_op1_o    = exe_op1_q;
  assign exe_op2_o    = exe_op2_q;
  assign exe_inst_o   = exe_inst_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_wdata_o  = rsp_wdata_q;
  assign rsp_we_o     = rsp_we_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_exe_share_arb.sv
// Scoreboard bench for exe_share_arb: a transaction-level model predicts grants,
// phases and responses; a negedge monitor compares against the DUT.
module tb_exe_share_arb;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
`ifdef EXE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic          id;
    logic [TW-1:0] tag;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [31:0]   inst;
  } req_t;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic rsp_rdy;
  logic v[2];
  logic [DW-1:0] op1[2];
  logic [DW-1:0] op2[2];
  logic [31:0]   inst[2];
  logic [TW-1:0] tag[2];

  logic rdy0, rdy1;
  logic [DW-1:0] exe_op1, exe_op2, exe_wdata;
  logic [31:0]   exe_inst;
  logic          exe_we;
  logic          rsp_valid, rsp_id, rsp_we, busy;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_wdata;

  int total = 0;
  int bad = 0;

  // Model state: phase 0 = idle, 1 = executing, 2 = response pending
  req_t q[$];
  req_t cur;
  req_t r;
  int   phase = 0;
  logic prio = 1'b0;
  logic acc[2];
  logic m_win, m_g0, m_g1;
  logic [DW:0] e;
  logic [DW-1:0] rlog_wdata[$];
  logic          rlog_id[$];

  always #5 clk = ~clk;

  exe_share_arb #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(v[0]), .req0_ready_o(rdy0), .req0_op1_i(op1[0]), .req0_op2_i(op2[0]),
    .req0_inst_i(inst[0]), .req0_tag_i(tag[0]),
    .req1_valid_i(v[1]), .req1_ready_o(rdy1), .req1_op1_i(op1[1]), .req1_op2_i(op2[1]),
    .req1_inst_i(inst[1]), .req1_tag_i(tag[1]),
    .exe_op1_o(exe_op1), .exe_op2_o(exe_op2), .exe_inst_o(exe_inst),
    .exe_wdata_i(exe_wdata), .exe_we_i(exe_we),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_tag_o(rsp_tag), .rsp_wdata_o(rsp_wdata), .rsp_we_o(rsp_we), .busy_o(busy)
  );

  // Behavioural I-type ALU: returns {we, result}; non-I-type gives zero with we=0.
  function automatic logic [DW:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic [31:0] ins);
    logic [DW-1:0] res;
    logic [4:0]    sh;
    if (ins[6:0] != 7'h13) return '0;
    sh = b[4:0];
    case (ins[14:12])
      3'd0: res = a + b;
      3'd1: res = a << sh;
      3'd2: res = DW'($signed(a) < $signed(b));
      3'd3: res = DW'(a < b);
      3'd4: res = a ^ b;
      3'd5: res = ins[30] ? DW'($signed(a) >>> sh) : (a >> sh);
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    return {1'b1, res};
  endfunction

  assign {exe_we, exe_wdata} = alu(exe_op1, exe_op2, exe_inst);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model one cycle
  always @(negedge clk) begin
    if (rst_i) begin
      q.delete();
      phase  = 0;
      prio   = 1'b0;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
    end else begin
      chk("busy", 64'(busy), 64'(phase != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(phase == 2));
      if (phase == 1) begin
        chk("exe_op1", 64'(exe_op1), 64'(cur.op1));
        chk("exe_op2", 64'(exe_op2), 64'(cur.op2));
        chk("exe_inst", 64'(exe_inst), 64'(cur.inst));
      end else begin
        chk("exe_idle", 64'({exe_op1, exe_op2}), 64'(0));
        chk("exe_inst_idle", 64'(exe_inst), 64'(0));
      end
      if (phase == 2) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_no_expected actual=response required=none @%0t", $time);
        end else begin
          e = alu(q[0].op1, q[0].op2, q[0].inst);
          chk("rsp_wdata", 64'(rsp_wdata), 64'(e[DW-1:0]));
          chk("rsp_we", 64'(rsp_we), 64'(e[DW]));
          chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
          chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
        end
      end
      m_win = (phase == 0) || (phase == 2 && rsp_rdy);
      m_g1  = m_win && v[1] && (!v[0] || (RR && prio));
      m_g0  = m_win && v[0] && !m_g1;
      chk("req0_ready", 64'(rdy0), 64'(m_g0));
      chk("req1_ready", 64'(rdy1), 64'(m_g1));
      acc[0] = rdy0 && v[0];
      acc[1] = rdy1 && v[1];
      if (phase == 2 && rsp_rdy && q.size() > 0) void'(q.pop_front());
      if (m_g0 || m_g1) begin
        r.id   = m_g1;
        r.tag  = m_g1 ? tag[1] : tag[0];
        r.op1  = m_g1 ? op1[1] : op1[0];
        r.op2  = m_g1 ? op2[1] : op2[0];
        r.inst = m_g1 ? inst[1] : inst[0];
        q.push_back(r);
        cur   = r;
        phase = 1;
        prio  = m_g0;
      end else if (m_win) begin
        phase = 0;
      end else if (phase == 1) begin
        phase = 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (acc[i]) v[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [31:0] ins, input logic [TW-1:0] t);
    v[i]    = 1'b1;
    op1[i]  = a;
    op2[i]  = b;
    inst[i] = ins;
    tag[i]  = t;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    v[0]  = 1'b0;
    v[1]  = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; op1[i] = '0; op2[i] = '0; inst[i] = '0; tag[i] = '0;
    end
    #1 rst_i = 1'b1;
    #1;
    chk("reset_outs", 64'({rsp_valid, rsp_we, rsp_id, busy, rdy0, rdy1}), 64'(0));
    chk("reset_data", 64'({rsp_wdata, rsp_tag}), 64'(0));
    chk("reset_exe", 64'({exe_op1, exe_inst}), 64'(0));
    step();
    step();
    rst_i = 1'b0;

    // Single ADDI
    issue(0, 32'd5, 32'd7, 32'h0000_0093, 4'd3);
    #1 chk("addi_ready", 64'(rdy0), 64'(1));
    step();
    chk("addi_busy", 64'(busy), 64'(1));
    step();
    chk("addi_valid", 64'(rsp_valid), 64'(1));
    chk("addi_wdata", 64'(rsp_wdata), 64'(12));
    chk("addi_we_id_tag", 64'({rsp_we, rsp_id, rsp_tag}), 64'({1'b1, 1'b0, 4'd3}));
    step();

    // Tie arbitration from a fresh prio
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (!v[0]) issue(0, 32'hF0, 32'h0F, 32'h0000_E093, 4'd1);
      if (!v[1]) issue(1, 32'hFF, 32'h0F, 32'h0000_F093, 4'd2);
      step();
      if (rsp_valid) begin
        rlog_id.push_back(rsp_id);
        rlog_wdata.push_back(rsp_wdata);
      end
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    chk("tie_count", 64'(rlog_id.size() >= 4), 64'(1));
    for (int n = 0; n < rlog_id.size(); n++) begin
      chk("tie_id", 64'(rlog_id[n]), RR ? 64'(n % 2) : 64'(0));
      chk("tie_wdata", 64'(rlog_wdata[n]), (RR && (n % 2 == 1)) ? 64'h0F : 64'hFF);
    end
    step();
    step();

    // Backpressure
    rsp_rdy = 1'b0;
    issue(0, 32'd100, 32'd1, 32'h0000_0093, 4'd4);
    step();
    step();
    issue(1, 32'd2, 32'd3, 32'h0000_4093, 4'd6);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ready1", 64'(rdy1), 64'(0));
      chk("bp_hold", 64'({rsp_valid, rsp_wdata}), 64'({1'b1, 32'd101}));
    end
    rsp_rdy = 1'b1;
    #1 chk("bp_release_ready1", 64'(rdy1), 64'(1));
    step();
    chk("bp_exec_gap", 64'({rsp_valid, busy}), 64'({1'b0, 1'b1}));
    step();
    chk("bp_rsp1", 64'({rsp_valid, rsp_id, rsp_tag, rsp_wdata}), 64'({1'b1, 1'b1, 4'd6, 32'd1}));
    step();

    // Non-I-type passthrough
    issue(0, 32'd9, 32'd9, 32'h0000_0033, 4'd5);
    step();
    step();
    chk("nonI_rsp", 64'({rsp_valid, rsp_we, rsp_wdata}), 64'({1'b1, 1'b0, 32'd0}));
    step();

    // Reset during EXEC
    issue(0, 32'd1, 32'd2, 32'h0000_0093, 4'd7);
    step();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_exec_outs", 64'({rsp_valid, rsp_we, rsp_id, busy, rdy0, rdy1}), 64'(0));
    chk("rst_exec_exe", 64'({exe_op1, exe_inst}), 64'(0));
    chk("rst_exec_rsp", 64'({rsp_wdata, rsp_tag}), 64'(0));
    @(posedge clk);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    issue(0, 32'd20, 32'd22, 32'h0000_0093, 4'd9);
    step();
    chk("post_rst_busy", 64'(busy), 64'(1));
    step();
    chk("post_rst_rsp", 64'({rsp_valid, rsp_wdata, rsp_tag}), 64'({1'b1, 32'd42, 4'd9}));
    step();

    // Randomized traffic with random backpressure
    for (int k = 0; k < 3000; k++) begin
      rsp_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && ($urandom_range(0, 2) == 0)) begin
          w = $urandom;
          w[6:0] = ($urandom_range(0, 3) == 0) ? 7'h33 : 7'h13;
          issue(i, $urandom, $urandom, w, TW'($urandom));
        end
      end
      step();
    end

    v[0] = 1'b0;
    v[1] = 1'b0;
    rsp_rdy = 1'b1;
    repeat (5) step();
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
